// File: rtl/game_pkg.sv
// Shared types and map geometry for the light-cycle game.
// Map tiles, player directions, round results, start cells and the
// heading-update rule used by the move scheduler.
package game_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PLAYER1 = 2'd1,
        PLAYER2 = 2'd2
    } tile;

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } directions;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUNNING = 3'd1,
        P1_WIN  = 3'd2,
        P2_WIN  = 3'd3,
        DRAW    = 3'd4
    } game_result;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } coord_t;

    // 63 x 48 cells of 16x16 pixels; the odd width keeps the two start
    // columns an even distance apart so head-on meetings are possible.
    localparam int MAP_WIDTH  = 63;
    localparam int MAP_HEIGHT = 48;

    localparam logic [7:0] LAST_X = 8'(MAP_WIDTH - 1);
    localparam logic [7:0] LAST_Y = 8'(MAP_HEIGHT - 1);

    localparam logic [7:0] P1_START_X = 8'd10;
    localparam logic [7:0] P1_START_Y = 8'd18;
    localparam logic [7:0] P2_START_X = 8'(MAP_WIDTH - 11);
    localparam logic [7:0] P2_START_Y = 8'd18;

    // A request is dropped when it is WAIT or would reverse the player onto
    // its own trail; anything else becomes the new heading.
    function automatic directions next_heading(input directions cur, input directions req);
        directions rev;
        case (cur)
            UP:      rev = DOWN;
            DOWN:    rev = UP;
            LEFT:    rev = RIGHT;
            RIGHT:   rev = LEFT;
            default: rev = WAIT;
        endcase
        if (req == WAIT || req == rev) return cur;
        return req;
    endfunction

endpackage

// File: rtl/move_scheduler_next_cell.sv
// next_cell: one step of a head position along a heading.
// Config macro: MOVE_SCHEDULER_WRAP_EN -- edges wrap to the opposite side
// and oob_o is never raised; otherwise stepping off the map flags oob_o.
module next_cell
    import game_pkg::*;
(
    input  coord_t    pos_i,
    input  directions dir_i,
    output coord_t    pos_o,
    output logic      oob_o
);

`ifdef MOVE_SCHEDULER_WRAP_EN
    // Step with wrap-around at every map edge
    always_comb begin
        pos_o = pos_i;
        case (dir_i)
            UP:      pos_o.y = (pos_i.y == 8'd0)   ? LAST_Y : pos_i.y - 8'd1;
            DOWN:    pos_o.y = (pos_i.y == LAST_Y) ? 8'd0   : pos_i.y + 8'd1;
            LEFT:    pos_o.x = (pos_i.x == 8'd0)   ? LAST_X : pos_i.x - 8'd1;
            RIGHT:   pos_o.x = (pos_i.x == LAST_X) ? 8'd0   : pos_i.x + 8'd1;
            default: ;
        endcase
    end

    assign oob_o = 1'b0;
`else
    // Plain 8-bit step; a decrement from 0 lands on 255 and is caught as out of range
    always_comb begin
        pos_o = pos_i;
        case (dir_i)
            UP:      pos_o.y = pos_i.y - 8'd1;
            DOWN:    pos_o.y = pos_i.y + 8'd1;
            LEFT:    pos_o.x = pos_i.x - 8'd1;
            RIGHT:   pos_o.x = pos_i.x + 8'd1;
            default: ;
        endcase
    end

    assign oob_o = (pos_o.x > LAST_X) || (pos_o.y > LAST_Y);
`endif

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: tick-driven game sequencer and sole writer of the map.
// Clears the map, places both players, then every TICK_DIV cycles reads the
// two next cells, resolves crashes and writes the new trail cells.
// Config macro: MOVE_SCHEDULER_WRAP_EN (edge wrap, handled in next_cell).
module move_scheduler
    import game_pkg::*;
#(
    parameter int TICK_DIV = 6_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  directions  dir_p1,
    input  directions  dir_p2,
    output logic [7:0] map_rd_x,
    output logic [7:0] map_rd_y,
    input  tile        map_rd_tile,
    output logic       map_wr_en,
    output logic [7:0] map_wr_x,
    output logic [7:0] map_wr_y,
    output tile        map_wr_tile,
    output logic [7:0] p1_x,
    output logic [7:0] p1_y,
    output logic [7:0] p2_x,
    output logic [7:0] p2_y,
    output game_result result,
    output logic       tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CLEAR, ST_PLACE, ST_WAIT_TICK, ST_RD_P1,
        ST_RD_P2, ST_RESOLVE, ST_WR_P1, ST_WR_P2, ST_DONE
    } state_t;

    state_t           state_q, state_d;
    game_result       result_q, result_d;
    coord_t           p1_q, p1_d, p2_q, p2_d;     // current heads
    coord_t           n1_q, n1_d, n2_q, n2_d;     // next cells latched at the tick
    logic             oob1_q, oob1_d, oob2_q, oob2_d;
    directions        hd1_q, hd1_d, hd2_q, hd2_d;
    tile              t1_q, t1_d;                 // p1's next-cell tile
    logic [CNT_W-1:0] cnt_q, cnt_d;
    coord_t           clr_q, clr_d;               // clear sweep cursor
    logic             place_q, place_d;           // 0: placing p1, 1: placing p2

    directions hd1_nx, hd2_nx;
    coord_t    nc1, nc2;
    logic      nc1_oob, nc2_oob;
    logic      same_cell, crash1, crash2;

    assign hd1_nx = next_heading(hd1_q, dir_p1);
    assign hd2_nx = next_heading(hd2_q, dir_p2);

    next_cell u_nc1 (.pos_i(p1_q), .dir_i(hd1_nx), .pos_o(nc1), .oob_o(nc1_oob));
    next_cell u_nc2 (.pos_i(p2_q), .dir_i(hd2_nx), .pos_o(nc2), .oob_o(nc2_oob));

    // p2's tile is used straight off the read port in RESOLVE
    assign same_cell = (n1_q == n2_q);
    assign crash1    = oob1_q || (t1_q != EMPTY) || same_cell;
    assign crash2    = oob2_q || (map_rd_tile != EMPTY) || same_cell;

    assign p1_x   = p1_q.x;
    assign p1_y   = p1_q.y;
    assign p2_x   = p2_q.x;
    assign p2_y   = p2_q.y;
    assign result = result_q;

    // State and datapath registers; reset abandons any sweep or move in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= IDLE;
            p1_q     <= '0;
            p2_q     <= '0;
            n1_q     <= '0;
            n2_q     <= '0;
            oob1_q   <= 1'b0;
            oob2_q   <= 1'b0;
            hd1_q    <= RIGHT;
            hd2_q    <= LEFT;
            t1_q     <= EMPTY;
            cnt_q    <= '0;
            clr_q    <= '0;
            place_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            n1_q     <= n1_d;
            n2_q     <= n2_d;
            oob1_q   <= oob1_d;
            oob2_q   <= oob2_d;
            hd1_q    <= hd1_d;
            hd2_q    <= hd2_d;
            t1_q     <= t1_d;
            cnt_q    <= cnt_d;
            clr_q    <= clr_d;
            place_q  <= place_d;
        end
    end

    // Next state, datapath updates and map port drive
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        n1_d        = n1_q;
        n2_d        = n2_q;
        oob1_d      = oob1_q;
        oob2_d      = oob2_q;
        hd1_d       = hd1_q;
        hd2_d       = hd2_q;
        t1_d        = t1_q;
        cnt_d       = '0;           // counter only survives while waiting
        clr_d       = clr_q;
        place_d     = place_q;
        map_rd_x    = '0;
        map_rd_y    = '0;
        map_wr_en   = 1'b0;
        map_wr_x    = '0;
        map_wr_y    = '0;
        map_wr_tile = EMPTY;
        tick        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    clr_d   = '0;
                end
            end

            ST_CLEAR: begin
                map_wr_en = 1'b1;
                map_wr_x  = clr_q.x;
                map_wr_y  = clr_q.y;
                if (clr_q.x == LAST_X) begin
                    clr_d.x = '0;
                    if (clr_q.y == LAST_Y) begin
                        clr_d.y = '0;
                        place_d = 1'b0;
                        state_d = ST_PLACE;
                    end else begin
                        clr_d.y = clr_q.y + 8'd1;
                    end
                end else begin
                    clr_d.x = clr_q.x + 8'd1;
                end
            end

            ST_PLACE: begin
                map_wr_en = 1'b1;
                if (!place_q) begin
                    map_wr_x    = P1_START_X;
                    map_wr_y    = P1_START_Y;
                    map_wr_tile = PLAYER1;
                    place_d     = 1'b1;
                end else begin
                    map_wr_x    = P2_START_X;
                    map_wr_y    = P2_START_Y;
                    map_wr_tile = PLAYER2;
                    place_d     = 1'b0;
                    p1_d        = '{x: P1_START_X, y: P1_START_Y};
                    p2_d        = '{x: P2_START_X, y: P2_START_Y};
                    hd1_d       = RIGHT;
                    hd2_d       = LEFT;
                    result_d    = RUNNING;
                    state_d     = ST_WAIT_TICK;
                end
            end

            ST_WAIT_TICK: begin
                if (cnt_q == CNT_LAST) begin
                    hd1_d   = hd1_nx;
                    hd2_d   = hd2_nx;
                    n1_d    = nc1;
                    n2_d    = nc2;
                    oob1_d  = nc1_oob;
                    oob2_d  = nc2_oob;
                    state_d = ST_RD_P1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RD_P1: begin
                if (!oob1_q) begin
                    map_rd_x = n1_q.x;
                    map_rd_y = n1_q.y;
                end
                state_d = ST_RD_P2;
            end

            ST_RD_P2: begin
                if (!oob2_q) begin
                    map_rd_x = n2_q.x;
                    map_rd_y = n2_q.y;
                end
                t1_d    = map_rd_tile;
                state_d = ST_RESOLVE;
            end

            ST_RESOLVE: begin
                if (!crash1 && !crash2) begin
                    state_d = ST_WR_P1;
                end else begin
                    if (crash1 && crash2) result_d = DRAW;
                    else if (crash1)      result_d = P2_WIN;
                    else                  result_d = P1_WIN;
                    state_d = ST_DONE;
                end
            end

            ST_WR_P1: begin
                map_wr_en   = 1'b1;
                map_wr_x    = n1_q.x;
                map_wr_y    = n1_q.y;
                map_wr_tile = PLAYER1;
                state_d     = ST_WR_P2;
            end

            ST_WR_P2: begin
                map_wr_en   = 1'b1;
                map_wr_x    = n2_q.x;
                map_wr_y    = n2_q.y;
                map_wr_tile = PLAYER2;
                tick        = 1'b1;
                p1_d        = n1_q;
                p2_d        = n2_q;
                state_d     = ST_WAIT_TICK;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler with a 1-cycle-read map model.
// Expected map writes are queued as stimulus is issued; a monitor pops and
// compares on every map_wr_en cycle and checks the tick spacing.
module tb_move_scheduler;
    import game_pkg::*;

    localparam int TD    = 16;
    localparam int NCELL = MAP_WIDTH * MAP_HEIGHT;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        tile        t;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    directions  dir_p1 = WAIT;
    directions  dir_p2 = WAIT;
    logic [7:0] map_rd_x, map_rd_y, map_wr_x, map_wr_y;
    tile        map_rd_tile;
    tile        map_wr_tile;
    logic       map_wr_en;
    logic [7:0] p1_x, p1_y, p2_x, p2_y;
    game_result result;
    logic       tick;

    move_scheduler #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dir_p1(dir_p1), .dir_p2(dir_p2),
        .map_rd_x(map_rd_x), .map_rd_y(map_rd_y), .map_rd_tile(map_rd_tile),
        .map_wr_en(map_wr_en), .map_wr_x(map_wr_x), .map_wr_y(map_wr_y),
        .map_wr_tile(map_wr_tile),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .result(result), .tick(tick)
    );

    always #5 clk = ~clk;

    tile mem [0:NCELL-1];

    always @(posedge clk) begin
        if (map_wr_en && map_wr_x < 8'(MAP_WIDTH) && map_wr_y < 8'(MAP_HEIGHT))
            mem[int'(map_wr_y) * MAP_WIDTH + int'(map_wr_x)] <= map_wr_tile;
        if (map_rd_x < 8'(MAP_WIDTH) && map_rd_y < 8'(MAP_HEIGHT))
            map_rd_tile <= mem[int'(map_rd_y) * MAP_WIDTH + int'(map_rd_x)];
        else
            map_rd_tile <= EMPTY;
    end

    wr_t sb[$];
    int  chk_n  = 0;
    int  pass_n = 0;
    int  e1x, e1y, e2x, e2y;

    task automatic chk(input string name, input int act, input int exp);
        chk_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic wr_t mk(input int x, input int y, input tile t);
        wr_t w;
        w.x = 8'(x);
        w.y = 8'(y);
        w.t = t;
        return w;
    endfunction

    // monitor: every map write is matched against the queue; ticks spaced TD+5
    initial begin : monitor
        int  cyc;
        int  last;
        wr_t a, e;
        cyc  = 0;
        last = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (result != RUNNING) last = -1;
            if (map_wr_en) begin
                a.x = map_wr_x;
                a.y = map_wr_y;
                a.t = map_wr_tile;
                chk_n++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected map write: got (%0d,%0d,%0d), want none",
                             a.x, a.y, a.t);
                end else begin
                    e = sb.pop_front();
                    if (a == e) pass_n++;
                    else $display("FAIL map write: got (%0d,%0d,%0d), want (%0d,%0d,%0d)",
                                  a.x, a.y, a.t, e.x, e.y, e.t);
                end
            end
            if (tick) begin
                if (last >= 0) chk("tick spacing", cyc - last, TD + 5);
                last = cyc;
            end
        end
    end

    task automatic wait_result(input game_result r, input int budget, input string name);
        int n;
        n = 0;
        while (result != r && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(result), int'(r));
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 64);
        if (!tick) begin
            chk_n++;
            $display("FAIL tick timeout: got no tick in %0d cycles, want one", n);
        end
    endtask

    task automatic check_pos(input string name);
        chk({name, " p1_x"}, p1_x, e1x);
        chk({name, " p1_y"}, p1_y, e1y);
        chk({name, " p2_x"}, p2_x, e2x);
        chk({name, " p2_y"}, p2_y, e2y);
    endtask

    // queue the full clear + placement, launch a round, wait for RUNNING
    task automatic start_round(input string name);
        for (int y = 0; y < MAP_HEIGHT; y++)
            for (int x = 0; x < MAP_WIDTH; x++)
                sb.push_back(mk(x, y, EMPTY));
        sb.push_back(mk(10, 18, PLAYER1));
        sb.push_back(mk(MAP_WIDTH - 11, 18, PLAYER2));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(RUNNING, NCELL + 20, {name, " running"});
        chk({name, " clear/place writes left"}, sb.size(), 0);
        e1x = 10; e1y = 18; e2x = MAP_WIDTH - 11; e2y = 18;
        check_pos({name, " start"});
    endtask

    // n moves with fixed requests; deltas are the hand-derived per-tick steps
    task automatic do_ticks(input directions d1, input directions d2, input int n,
                            input int dx1, input int dy1, input int dx2, input int dy2);
        dir_p1 = d1;
        dir_p2 = d2;
        for (int i = 0; i < n; i++) begin
            e1x += dx1; e1y += dy1; e2x += dx2; e2y += dy2;
            sb.push_back(mk(e1x, e1y, PLAYER1));
            sb.push_back(mk(e2x, e2y, PLAYER2));
            wait_tick();
        end
        @(negedge clk);
    endtask

    task automatic do_crash(input directions d1, input directions d2,
                            input game_result r, input string name);
        dir_p1 = d1;
        dir_p2 = d2;
        wait_result(r, TD + 16, name);
        chk({name, " queued writes"}, sb.size(), 0);
        check_pos({name, " hold"});
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("reset result", int'(result), int'(IDLE));
        chk("reset wr_en", map_wr_en, 0);
        chk("reset tick", tick, 0);
        chk("reset p1_x", p1_x, 0);
        chk("reset p2_y", p2_y, 0);
        chk("reset rd addr", {map_rd_x, map_rd_y}, 0);
        chk("reset wr addr", {map_wr_x, map_wr_y, 6'd0, map_wr_tile}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle hold", int'(result), int'(IDLE));

        // round 1: straight run, ignored reverse, turns, then the right edge
        start_round("r1");
        do_ticks(WAIT, WAIT, 3, 1, 0, -1, 0);
        check_pos("r1 three ticks");
        chk("r1 p2_x = W-14", p2_x, MAP_WIDTH - 14);
        start = 1'b1;                       // ignored while RUNNING
        @(negedge clk);
        start = 1'b0;
        do_ticks(LEFT, WAIT, 1, 1, 0, -1, 0);
        check_pos("r1 reverse ignored");
        do_ticks(UP, DOWN, 13, 0, -1, 0, 1);
        check_pos("r1 turn");
        do_ticks(RIGHT, LEFT, 40, 1, 0, -1, 0);
        do_ticks(WAIT, DOWN, 8, 1, 0, 0, 1);
        check_pos("r1 at edge");
`ifdef MOVE_SCHEDULER_WRAP_EN
        do_ticks(WAIT, WAIT, 1, -(MAP_WIDTH - 1), 0, 0, 1);
        check_pos("r1 wrap");
        chk("r1 wrap running", int'(result), int'(RUNNING));
`else
        do_crash(WAIT, WAIT, P2_WIN, "r1 edge crash");
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("r1 rst result", int'(result), int'(IDLE));
        chk("r1 rst wr_en", map_wr_en, 0);
        rst = 1'b0;
        @(negedge clk);

        // round 2: heads close on row 18 until both target the same cell
        start_round("r2");
        do_ticks(WAIT, WAIT, 20, 1, 0, -1, 0);
        check_pos("r2 two apart");
        do_crash(WAIT, WAIT, DRAW, "r2 head-on");

        // round 3: restart from DONE; p2 dives into p1's trail
        start_round("r3");
        do_ticks(WAIT, UP, 1, 1, 0, 0, -1);
        do_ticks(WAIT, LEFT, 1, 1, 0, -1, 0);
        do_ticks(WAIT, WAIT, 20, 1, 0, -1, 0);
        check_pos("r3 above trail");
        do_crash(WAIT, DOWN, P1_WIN, "r3 trail hit");

        // reset ten cells into the next clear sweep
        for (int x = 0; x < 10; x++) sb.push_back(mk(x, 0, EMPTY));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("clear abort result", int'(result), int'(IDLE));
        chk("clear abort wr_en", map_wr_en, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("clear abort writes left", sb.size(), 0);
        chk("clear abort stays idle", map_wr_en, 0);

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2000000, want finish");
        $fatal(1);
    end

endmodule
